// File: rtl/cmn_credit_sender.sv
// cmn_credit_sender: credit-based flow-control front end.
// Accepts messages on a val/rdy port, forwards them on a valid-only send port,
// spends one credit per message and reclaims credits returned by the consumer.
// A drain request stops new traffic until every credit is home, then pulses
// drain_done.
// Optional build macro: CMN_CREDIT_SENDER_OUT_REG_EN registers the send port
// (one-cycle latency). Without it the send port is a combinational pass-through.
module cmn_credit_sender #(
  parameter int p_msg_nbits    = 8,
  parameter int p_credit_nbits = 3,
  parameter int p_max_credits  = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [p_msg_nbits-1:0]    recv_msg,
  input  logic                      recv_val,
  output logic                      recv_rdy,
  output logic [p_msg_nbits-1:0]    send_msg,
  output logic                      send_val,
  input  logic                      credit_return,
  input  logic                      drain_req,
  output logic                      drain_done,
  output logic [p_credit_nbits-1:0] credits,
  output logic                      credits_zero,
  output logic                      credits_full,
  output logic                      credit_err
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [p_credit_nbits-1:0] MAX_CRED = p_credit_nbits'(p_max_credits);

  state_t                    state_q, state_d;
  logic [p_credit_nbits-1:0] credits_q, credits_d;
  logic                      credit_err_q, credit_err_d;
  logic                      xfer;

  // Handshake and status decode; drain_req closes the door in the cycle it is seen
  always_comb begin
    recv_rdy     = (state_q == RUN) && (credits_q != '0) && !drain_req;
    xfer         = recv_val && recv_rdy;
    drain_done   = (state_q == DRAIN) && (credits_q == MAX_CRED);
    credits      = credits_q;
    credits_zero = (credits_q == '0);
    credits_full = (credits_q == MAX_CRED);
    credit_err   = credit_err_q;
  end

  // Next-state for FSM, credit pool and sticky overflow flag
  always_comb begin
    state_d      = state_q;
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    case (state_q)
      INIT: begin
        // Returns arriving before the pool is loaded are deliberately dropped
        credits_d = MAX_CRED;
        state_d   = RUN;
      end
      default: begin
        if (xfer && !credit_return) begin
          credits_d = credits_q - 1'b1;
        end else if (credit_return && !xfer) begin
          if (credits_q < MAX_CRED) begin
            credits_d = credits_q + 1'b1;
          end else begin
            credit_err_d = 1'b1;
          end
        end
        if (state_q == RUN) begin
          state_d = drain_req ? DRAIN : RUN;
        end else if (drain_done) begin
          // Back to RUN; a still-high drain_req re-enters DRAIN next cycle
          state_d = RUN;
        end
      end
    endcase
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= INIT;
      credits_q    <= '0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
    end
  end

`ifdef CMN_CREDIT_SENDER_OUT_REG_EN
  logic                   send_val_q, send_val_d;
  logic [p_msg_nbits-1:0] send_msg_q, send_msg_d;

  // Capture accepted message; message holds its last value when idle
  always_comb begin
    send_val_d = xfer;
    send_msg_d = xfer ? recv_msg : send_msg_q;
  end

  // Send port registers; reset drops any in-flight send
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      send_val_q <= 1'b0;
      send_msg_q <= '0;
    end else begin
      send_val_q <= send_val_d;
      send_msg_q <= send_msg_d;
    end
  end

  assign send_val = send_val_q;
  assign send_msg = send_msg_q;
`else
  assign send_val = xfer;
  assign send_msg = recv_msg;
`endif

endmodule

// File: tb/tb_cmn_credit_sender.sv
// Scoreboard bench for cmn_credit_sender: stimulus drives a cycle-level
// reference of the credit rules and queues accepted messages; an independent
// monitor pops the queue whenever the DUT presents send_val.
module tb_cmn_credit_sender;

  localparam int MAX = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] recv_msg = '0;
  logic       recv_val = 1'b0;
  logic       recv_rdy;
  logic [7:0] send_msg;
  logic       send_val;
  logic       credit_return = 1'b0;
  logic       drain_req = 1'b0;
  logic       drain_done;
  logic [2:0] credits;
  logic       credits_zero;
  logic       credits_full;
  logic       credit_err;

  int total = 0;
  int bad   = 0;

  // Reference: 0 = loading pool, 1 = running, 2 = draining
  int         m_mode = 0;
  int         m_cred = 0;
  bit         m_err  = 1'b0;
  bit         prev_xfer = 1'b0;
  logic [7:0] q[$];

  cmn_credit_sender #(
    .p_msg_nbits(8),
    .p_credit_nbits(3),
    .p_max_credits(MAX)
  ) dut (
    .clk(clk),
    .reset(reset_n),
    .recv_msg(recv_msg),
    .recv_val(recv_val),
    .recv_rdy(recv_rdy),
    .send_msg(send_msg),
    .send_val(send_val),
    .credit_return(credit_return),
    .drain_req(drain_req),
    .drain_done(drain_done),
    .credits(credits),
    .credits_zero(credits_zero),
    .credits_full(credits_full),
    .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: apply inputs, predict, check mid-cycle, advance reference at the edge
  task automatic step(input bit val, input logic [7:0] msg, input bit ret, input bit drn);
    bit rdy, xfer, done, exp_sv;
    recv_val      = val;
    recv_msg      = msg;
    credit_return = ret;
    drain_req     = drn;
    rdy  = (m_mode == 1) && (m_cred != 0) && !drn;
    xfer = rdy && val;
    done = (m_mode == 2) && (m_cred == MAX);
    if (xfer) q.push_back(msg);
`ifdef CMN_CREDIT_SENDER_OUT_REG_EN
    exp_sv = prev_xfer;
`else
    exp_sv = xfer;
`endif
    @(negedge clk);
    chk("recv_rdy", int'(recv_rdy), int'(rdy));
    chk("credits", int'(credits), m_cred);
    chk("credits_zero", int'(credits_zero), int'(m_cred == 0));
    chk("credits_full", int'(credits_full), int'(m_cred == MAX));
    chk("credit_err", int'(credit_err), int'(m_err));
    chk("drain_done", int'(drain_done), int'(done));
    chk("send_val", int'(send_val), int'(exp_sv));
    @(posedge clk);
    if (m_mode == 0) begin
      m_cred = MAX;
      m_mode = 1;
    end else begin
      if (xfer && !ret) m_cred = m_cred - 1;
      else if (ret && !xfer) begin
        if (m_cred < MAX) m_cred = m_cred + 1;
        else m_err = 1'b1;
      end
      if (m_mode == 1) m_mode = drn ? 2 : 1;
      else if (done) m_mode = 1;
    end
    prev_xfer = xfer;
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_send_val"}, int'(send_val), 0);
    chk({tag, "_credits"}, int'(credits), 0);
    chk({tag, "_credit_err"}, int'(credit_err), 0);
    chk({tag, "_recv_rdy"}, int'(recv_rdy), 0);
    chk({tag, "_drain_done"}, int'(drain_done), 0);
    chk({tag, "_credits_zero"}, int'(credits_zero), 1);
  endtask

  // Monitor: every presented send must match the oldest queued message
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && send_val) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL send_msg: unexpected send 0x%02h with empty queue at %0t", send_msg, $time);
        end else begin
          logic [7:0] e;
          e = q.pop_front();
          if (send_msg !== e) begin
            bad++;
            $display("FAIL send_msg: got 0x%02h expected 0x%02h at %0t", send_msg, e, $time);
          end
        end
      end
    end
  end

  initial begin
    bit drn_l;
    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    reset_n = 1'b1;
    m_mode = 0; m_cred = 0; m_err = 0; prev_xfer = 0;

    // Fill-out: INIT cycle then exactly four transfers 0x11..0x14
    for (int k = 0; k < 7; k++) step(1'b1, 8'(8'h10 + k), 1'b0, 1'b0);
    // One return at zero credits: usable next cycle only
    step(1'b1, 8'h20, 1'b1, 1'b0);
    step(1'b1, 8'h21, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    // Two credits, then simultaneous transfer and return
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h30, 1'b1, 1'b0);
    // Fill to max, then overflow return
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    // Down to one credit, then drain with a pending recv_val
    for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h40 + k), 1'b0, 1'b0);
    step(1'b1, 8'h50, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h51 + k), 1'b1, 1'b1);
    step(1'b1, 8'h54, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b0, 1'b0);
    // Held drain request: repeated pulses while full
    for (int k = 0; k < 6; k++) step(1'b0, 8'h00, 1'b1, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Mid-stream reset with an active send
    step(1'b1, 8'h66, 1'b0, 1'b0);
    recv_val = 1'b1;
    recv_msg = 8'h77;
    credit_return = 1'b0;
    #1;
    chk("pre_reset_send_val", int'(send_val), 1);
    reset_n = 1'b0;
    #1;
    chk_reset_state("async");
    q.delete();
    m_mode = 0; m_cred = 0; m_err = 0; prev_xfer = 0;
    @(negedge clk);
    chk_reset_state("held");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h80 + k), 1'b0, 1'b0);

    // Randomized traffic, returns and drain requests
    drn_l = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 19) == 0) drn_l = !drn_l;
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0, drn_l);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
